// File: rtl/ahb_aes_sub.sv
`default_nettype none
// ============================================================================
// Module   : ahb_aes_sub
// Purpose  : AHB-Lite subordinate register front end for an external AES core.
//            Option macro AES_SUB_BUSY_STALL_EN: stall (instead of drop) writes
//            to CTRL/KEY/DIN while an operation is in flight.
// Revision : 1.0
// ============================================================================
module ahb_aes_sub (
   input  logic         hclk,
   input  logic         hrstn,
   input  logic         hsel,
   input  logic [31:0]  haddr,
   input  logic [1:0]   htrans,
   input  logic         hwrite,
   input  logic [2:0]   hsize,
   input  logic [2:0]   hburst,
   input  logic [31:0]  hwdata,
   input  logic         hready,
   output logic [31:0]  hrdata,
   output logic         hreadyOut,
   output logic         hresp,
   output logic         aes_start,
   output logic         aes_mode,
   output logic [127:0] aes_key,
   output logic [127:0] aes_din,
   input  logic [127:0] aes_dout,
   input  logic         aes_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_ERR1 = 2'd2,
      S_ERR2 = 2'd3
   } state_t;

   localparam logic [3:0] BLK_KEY  = 4'd1;
   localparam logic [3:0] BLK_DIN  = 4'd2;
   localparam logic [3:0] BLK_DOUT = 4'd3;

   state_t         state_q, state_d;
   logic [7:0]     addr_q, addr_d;
   logic           write_q, write_d;
   logic [1:0]     size_q, size_d;
   logic           mode_q, mode_d;
   logic           start_q, start_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           werr_q, werr_d;
   logic [127:0]   key_q, key_d;
   logic [127:0]   din_q, din_d;
   logic [127:0]   dout_q, dout_d;

   // hburst and the upper address bits play no part in decoding
   logic unused_bits;
   assign unused_bits = ^{hburst, haddr[31:8]};

   // ---------------- address phase decode ----------------
   logic       accept, addr_err, size_bad, misalign, mapped;
   logic [5:0] widx;

   assign widx     = haddr[7:2];
   assign size_bad = hsize[2] | (hsize[1] & hsize[0]);
   assign misalign = ((hsize == 3'b001) && haddr[0]) ||
                     ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
   assign mapped   = (widx[5:1] == 5'd0) ||
                     ((widx[5:4] == 2'd0) && (widx[3:2] != 2'd0));
   assign addr_err = size_bad | misalign | ~mapped |
                     (hwrite & (widx[5:2] == BLK_DOUT));

   // ---------------- data phase decode ----------------
   logic [5:0]  dwidx;
   logic        sel_ctrl, sel_stat, sel_key, sel_din, sel_dout;
   logic        data_ph, guarded, stall, discard, ready, wr_en;
   logic [3:0]  be;
   logic [31:0] mask, rd_word, merged;
   logic [6:0]  woff;

   assign dwidx    = addr_q[7:2];
   assign woff     = {dwidx[1:0], 5'd0};
   assign sel_ctrl = (dwidx == 6'd0);
   assign sel_stat = (dwidx == 6'd1);
   assign sel_key  = (dwidx[5:2] == BLK_KEY);
   assign sel_din  = (dwidx[5:2] == BLK_DIN);
   assign sel_dout = (dwidx[5:2] == BLK_DOUT);
   assign data_ph  = (state_q == S_DATA);
   assign guarded  = write_q & busy_q & (sel_ctrl | sel_key | sel_din);

`ifdef AES_SUB_BUSY_STALL_EN
   assign stall   = data_ph & guarded;
   assign discard = 1'b0;
`else
   assign stall   = 1'b0;
   assign discard = data_ph & guarded;
`endif

   assign ready  = (state_q != S_ERR1) & ~stall;
   assign accept = hsel & hready & htrans[1] & ready;
   assign wr_en  = data_ph & write_q & ~stall & ~discard;

   always_comb begin
      case (size_q)
         2'b00:   be = 4'b0001 << addr_q[1:0];
         2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   assign mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   assign merged = (rd_word & ~mask) | (hwdata & mask);

   always_comb begin
      rd_word = 32'd0;
      if (sel_ctrl)      rd_word = {30'd0, mode_q, 1'b0};
      else if (sel_stat) rd_word = {29'd0, werr_q, done_q, busy_q};
      else if (sel_key)  rd_word = key_q[woff +: 32];
      else if (sel_din)  rd_word = din_q[woff +: 32];
      else if (sel_dout) rd_word = dout_q[woff +: 32];
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      size_d  = size_q;
      mode_d  = mode_q;
      start_d = 1'b0;
      busy_d  = busy_q;
      done_d  = done_q;
      werr_d  = werr_q;
      key_d   = key_q;
      din_d   = din_q;
      dout_d  = dout_q;

      if (ready) begin
         if (accept) begin
            state_d = addr_err ? S_ERR1 : S_DATA;
            addr_d  = haddr[7:0];
            write_d = hwrite;
            size_d  = hsize[1:0];
         end else begin
            state_d = S_IDLE;
         end
      end else if (state_q == S_ERR1) begin
         state_d = S_ERR2;
      end

      if (wr_en) begin
         if (sel_ctrl && be[0]) begin
            mode_d = hwdata[1];
            if (hwdata[0] && !busy_q) begin
               start_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         if (sel_stat && be[0]) begin
            done_d = done_q & ~hwdata[1];
            werr_d = werr_q & ~hwdata[2];
         end
         if (sel_key) key_d[woff +: 32] = merged;
         if (sel_din) din_d[woff +: 32] = merged;
      end

      if (discard) werr_d = 1'b1;

      // completion is applied last so it wins over a same-cycle done clear
      if (aes_done && busy_q) begin
         dout_d = aes_dout;
         busy_d = 1'b0;
         done_d = 1'b1;
      end
   end

   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         state_q <= S_IDLE;
         addr_q  <= 8'd0;
         write_q <= 1'b0;
         size_q  <= 2'd0;
         mode_q  <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         werr_q  <= 1'b0;
         key_q   <= 128'd0;
         din_q   <= 128'd0;
         dout_q  <= 128'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         size_q  <= size_d;
         mode_q  <= mode_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         werr_q  <= werr_d;
         key_q   <= key_d;
         din_q   <= din_d;
         dout_q  <= dout_d;
      end
   end

   assign hreadyOut = ready;
   assign hresp     = (state_q == S_ERR1) | (state_q == S_ERR2);
   assign hrdata    = (data_ph && !write_q) ? rd_word : 32'd0;
   assign aes_start = start_q;
   assign aes_mode  = mode_q;
   assign aes_key   = key_q;
   assign aes_din   = din_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_aes_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_aes_sub
// Purpose  : Directed, table-driven bench for ahb_aes_sub with a scripted AES core.
// Revision : 1.0
// ============================================================================
module tb_ahb_aes_sub;

   logic         hclk = 1'b0;
   logic         hrstn;
   logic         hsel;
   logic [31:0]  haddr;
   logic [1:0]   htrans;
   logic         hwrite;
   logic [2:0]   hsize;
   logic [2:0]   hburst;
   logic [31:0]  hwdata;
   logic         hready;
   logic [31:0]  hrdata;
   logic         hready_out;
   logic         hresp;
   logic         aes_start;
   logic         aes_mode;
   logic [127:0] aes_key;
   logic [127:0] aes_din;
   logic [127:0] aes_dout;
   logic         aes_done;

   // code: 0 zero-wait OKAY, 1 two-cycle ERROR, 2 OKAY after waits, 3 bad/timeout
   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [31:0] exp;
      int          code;
   } vec_t;

   vec_t vecs[$];
   int   n_pass = 0;
   int   n_total = 0;
   logic [31:0] r_b;
   int   c_b, w_b;

   assign hready = hready_out;

   always #5 hclk = ~hclk;

   ahb_aes_sub dut (
      .hclk      (hclk),
      .hrstn     (hrstn),
      .hsel      (hsel),
      .haddr     (haddr),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hburst    (hburst),
      .hwdata    (hwdata),
      .hready    (hready),
      .hrdata    (hrdata),
      .hreadyOut (hready_out),
      .hresp     (hresp),
      .aes_start (aes_start),
      .aes_mode  (aes_mode),
      .aes_key   (aes_key),
      .aes_din   (aes_din),
      .aes_dout  (aes_dout),
      .aes_done  (aes_done)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic add(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [31:0] exp, input int code);
      vec_t v;
      v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata; v.exp = exp; v.code = code;
      vecs.push_back(v);
   endtask

   // One non-pipelined transfer; returns at the negedge of its final data-phase cycle.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output int code, output int waits);
      logic first_resp, last_resp, fin;
      @(posedge hclk); #1;
      hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
      @(posedge hclk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
      fin = 1'b0; waits = 0; first_resp = 1'b0; last_resp = 1'b0; rdata = '0;
      for (int k = 0; k < 64 && !fin; k++) begin
         @(negedge hclk);
         if (hready_out) begin
            fin = 1'b1; rdata = hrdata; last_resp = hresp;
         end else begin
            if (waits == 0) first_resp = hresp;
            waits++;
         end
      end
      if (!fin)                                          code = 3;
      else if (waits == 0)                               code = last_resp ? 3 : 0;
      else if (waits == 1 && first_resp && last_resp)    code = 1;
      else if (!first_resp && !last_resp)                code = 2;
      else                                               code = 3;
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
      logic [31:0] d; int c, w;
      xfer(1'b0, addr, 3'd2, 32'd0, d, c, w);
      check({name, "_resp"}, c, 0);
      check({name, "_data"}, d, exp);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input string name);
      logic [31:0] d; int c, w;
      xfer(1'b1, addr, 3'd2, data, d, c, w);
      check({name, "_resp"}, c, 0);
   endtask

   task automatic pulse_done(input logic [127:0] dout);
      @(posedge hclk); #1;
      aes_dout = dout; aes_done = 1'b1;
      @(posedge hclk); #1;
      aes_done = 1'b0;
   endtask

   initial begin
      hrstn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
      hsize = 3'd0; hburst = 3'd0; hwdata = '0; aes_dout = '0; aes_done = 1'b0;

      repeat (3) @(posedge hclk);
      #1;
      check("rst_hreadyout", hready_out, 1'b1);
      check("rst_hresp", hresp, 1'b0);
      check("rst_hrdata", hrdata, 32'd0);
      check("rst_start", aes_start, 1'b0);
      check("rst_key_din_mode", {aes_key, aes_din, aes_mode}, '0);
      @(negedge hclk);
      hrstn = 1'b1;

      // ---------------- vector table ----------------
      add(0, 32'h04, 3'd2, 0, 32'h0, 0);
      add(0, 32'h00, 3'd2, 0, 32'h0, 0);
      for (int i = 0; i < 4; i++) add(1, 32'h10 + 4*i, 3'd2, 32'h11223344, 0, 0);
      for (int i = 0; i < 4; i++) add(1, 32'h20 + 4*i, 3'd2, 32'h11223344, 0, 0);
      for (int i = 0; i < 4; i++) add(0, 32'h10 + 4*i, 3'd2, 0, 32'h11223344, 0);
      for (int i = 0; i < 4; i++) add(0, 32'h20 + 4*i, 3'd2, 0, 32'h11223344, 0);
      add(1, 32'h20, 3'd2, 32'h00000000, 0, 0);
      add(1, 32'h21, 3'd0, 32'h0000AB00, 0, 0);
      add(0, 32'h20, 3'd2, 0, 32'h0000AB00, 0);
      add(1, 32'h22, 3'd1, 32'hBEEF0000, 0, 0);
      add(0, 32'h20, 3'd2, 0, 32'hBEEFAB00, 0);
      add(1, 32'h1F, 3'd0, 32'h99000000, 0, 0);
      add(0, 32'h1C, 3'd2, 0, 32'h99223344, 0);
      add(0, 32'h00, 3'd3, 0, 0, 1);
      add(1, 32'h30, 3'd2, 32'hDEADBEEF, 0, 1);
      add(1, 32'h22, 3'd2, 32'hFFFFFFFF, 0, 1);
      add(1, 32'h21, 3'd1, 32'hFFFFFFFF, 0, 1);
      add(0, 32'h08, 3'd2, 0, 0, 1);
      add(1, 32'h40, 3'd2, 32'hFFFFFFFF, 0, 1);
      add(1, 32'h24, 3'd3, 32'hFFFFFFFF, 0, 1);
      add(0, 32'h20, 3'd2, 0, 32'hBEEFAB00, 0);
      add(0, 32'h24, 3'd2, 0, 32'h11223344, 0);
      add(0, 32'h30, 3'd2, 0, 32'h00000000, 0);
      add(0, 32'h04, 3'd2, 0, 32'h00000000, 0);
      add(1, 32'h00, 3'd2, 32'h00000002, 0, 0);
      add(0, 32'h00, 3'd2, 0, 32'h00000002, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, r_b, c_b, w_b);
         check($sformatf("vec%0d_resp", i), c_b, vecs[i].code);
         if (!vecs[i].wr && vecs[i].code == 0)
            check($sformatf("vec%0d_data", i), r_b, vecs[i].exp);
      end

      check("core_mode", aes_mode, 1'b1);
      check("core_key", aes_key, {32'h99223344, 32'h11223344, 32'h11223344, 32'h11223344});
      check("core_din", aes_din, {32'h11223344, 32'h11223344, 32'h11223344, 32'hBEEFAB00});

      // ---------------- start / done ----------------
      wr(32'h00, 32'h1, "start1");
      @(negedge hclk);
      check("start_pulse_hi", {aes_start, aes_mode}, 2'b10);
      @(negedge hclk);
      check("start_pulse_lo", aes_start, 1'b0);
      rd(32'h04, 32'h1, "stat_busy");
      pulse_done(128'h0F);
      rd(32'h04, 32'h2, "stat_done");
      rd(32'h30, 32'h0000000F, "dout0");
      rd(32'h3C, 32'h0, "dout3");

      // ---------------- write while busy ----------------
      wr(32'h00, 32'h1, "start2");
      rd(32'h04, 32'h3, "stat_busy_done");
      fork
         xfer(1'b1, 32'h20, 3'd2, 32'h55667788, r_b, c_b, w_b);
         begin
            repeat (6) @(posedge hclk);
            #1; aes_dout = 128'hA5; aes_done = 1'b1;
            @(posedge hclk);
            #1; aes_done = 1'b0;
         end
      join
`ifdef AES_SUB_BUSY_STALL_EN
      check("busy_wr_resp", c_b, 2);
      rd(32'h20, 32'h55667788, "busy_wr_din0");
      rd(32'h04, 32'h2, "busy_wr_stat");
`else
      check("busy_wr_resp", c_b, 0);
      rd(32'h20, 32'hBEEFAB00, "busy_wr_din0");
      rd(32'h04, 32'h6, "busy_wr_stat");
`endif
      rd(32'h30, 32'hA5, "dout0_b");
      wr(32'h04, 32'h6, "w1c");
      rd(32'h04, 32'h0, "w1c_stat");

      // ---------------- done set vs write-1-to-clear on the same edge ----------------
      wr(32'h00, 32'h1, "start3");
      pulse_done(128'h01);
      wr(32'h00, 32'h1, "start4");
      @(posedge hclk); #1;
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h04; hwrite = 1'b1; hsize = 3'd2;
      @(posedge hclk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = 32'h2; aes_dout = 128'h77; aes_done = 1'b1;
      @(negedge hclk);
      check("race_okay", {hready_out, hresp}, 2'b10);
      @(posedge hclk); #1;
      aes_done = 1'b0;
      rd(32'h04, 32'h2, "race_stat");
      rd(32'h30, 32'h77, "race_dout0");

      // ---------------- reset during ERROR first cycle ----------------
      wr(32'h00, 32'h1, "start5");
      @(posedge hclk); #1;
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h00; hwrite = 1'b0; hsize = 3'd3;
      @(posedge hclk); #1;
      hsel = 1'b0; htrans = 2'b00;
      @(negedge hclk);
      check("err1_phase", {hready_out, hresp}, 2'b01);
      #2 hrstn = 1'b0;
      #1;
      check("rst_err_bus", {hready_out, hresp, hrdata}, {2'b10, 32'd0});
      check("rst_err_core", {aes_start, aes_mode, aes_key, aes_din}, '0);
      @(posedge hclk);
      @(negedge hclk);
      hrstn = 1'b1;
      pulse_done(128'hFF);
      rd(32'h04, 32'h0, "post_rst_stat");
      rd(32'h30, 32'h0, "post_rst_dout0");
      rd(32'h10, 32'h0, "post_rst_key0");
      rd(32'h20, 32'h0, "post_rst_din0");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ahb_aes_sub.md
AHB_AES_SUB -- requirements
Module: ahb_aes_sub

Interface
REQ-001 SHALL have port hclk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port hrstn, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port hsel, input, 1, subordinate select.
REQ-004 SHALL have port haddr, input, 32, byte address; only haddr[7:0] decoded.
REQ-005 SHALL have port htrans, input, 2, IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-006 SHALL have ports hwrite (input, 1), hsize (input, 3), hburst (input, 3), hwdata (input, 32).
REQ-007 SHALL have port hready, input, 1, bus-level ready; address phase sampled only when high.
REQ-008 SHALL have ports hrdata (output, 32), hreadyOut (output, 1), hresp (output, 1, 0=OKAY, 1=ERROR).
REQ-009 SHALL have AES-core ports: aes_start (output, 1, pulse), aes_mode (output, 1, 0=enc), aes_key (output, 128), aes_din (output, 128), aes_dout (input, 128), aes_done (input, 1, pulse).

Function
REQ-010 SHALL accept a transfer when hsel & hready & htrans[1] at a rising edge, registering haddr[7:0], hwrite and hsize for the data phase.
REQ-011 SHALL give IDLE/BUSY or unselected transfers a zero-wait OKAY response; hburst is ignored, each beat decoded individually.
REQ-012 SHALL map registers: 0x00 CTRL (bit0 start, write-only self-clearing; bit1 mode), 0x04 STATUS (bit0 busy, bit1 done, bit2 werr; done/werr write-1-to-clear), 0x10-0x1C KEY[0..3], 0x20-0x2C DIN[0..3], 0x30-0x3C DOUT[0..3] read-only; word 0 = bits [31:0].
REQ-013 SHALL support hsize 000 (any byte lane), 001 (haddr[0]=0) and 010 (haddr[1:0]=00), little-endian lanes; writes update only addressed bytes; reads return the full word.
REQ-014 SHALL respond ERROR for hsize >= 011, misaligned address, unmapped address, or write to DOUT; no register changes.
REQ-015 SHALL issue ERROR as two cycles: hreadyOut=0,hresp=1 then hreadyOut=1,hresp=1.
REQ-016 SHALL complete legal reads and writes with zero wait states; write data taken from hwdata in the data phase; hrdata valid in the data-phase cycle with hreadyOut=1.
REQ-017 SHALL, on a CTRL write with bit0=1 while not busy, pulse aes_start for exactly one cycle on the next edge and set busy.
REQ-018 SHALL, on aes_done, capture aes_dout into DOUT, clear busy and set done in the same edge; aes_done while not busy is ignored.
REQ-019 SHALL drive aes_key/aes_din/aes_mode continuously from KEY/DIN/CTRL.bit1.
REQ-020 SHALL give a simultaneous aes_done and STATUS write-1-to-clear of done priority to the set (done remains 1).

Reset
REQ-021 SHALL, while hrstn=0, force hreadyOut=1, hresp=0, hrdata=0, aes_start=0, aes_mode=0, KEY/DIN/DOUT=0, busy=done=werr=0, and cancel any pending data phase or ERROR sequence.
REQ-022 SHALL resume normal operation on the first rising edge after hrstn deasserts; an AES operation in flight is abandoned (later aes_done ignored).

Configuration
REQ-023 SHALL use macro AES_SUB_BUSY_STALL_EN: defined, a write to CTRL/KEY/DIN while busy holds hreadyOut=0 (hresp=0) until busy clears, then completes; undefined, such writes complete zero-wait OKAY, are discarded, and set STATUS.werr.

Verification
REQ-024 SHALL cover: word writes 0x11223344 to KEY0..3 and DIN0..3, read back -> identical values, zero wait, OKAY.
REQ-025 SHALL cover: byte write 0xAB at 0x21 over DIN0=0 -> DIN0 reads 0x0000AB00.
REQ-026 SHALL cover: hsize=011 read at 0x00, and word write to 0x30 -> two-cycle ERROR each, registers unchanged.
REQ-027 SHALL cover: CTRL write 0x1 -> aes_start one cycle, STATUS=0x1; aes_done with aes_dout=0x0..0F -> STATUS=0x2, DOUT0 reads 0x0000000F.
REQ-028 SHALL cover: DIN0 write while busy -> with macro, hreadyOut low until aes_done then DIN0 updated; without, OKAY, DIN0 unchanged, STATUS.werr=1.
REQ-029 SHALL cover: hrstn low during ERROR first cycle -> hreadyOut=1, hresp=0 immediately, all registers 0.
